// File: rtl/tl_tx_fc_arbiter.sv
// Transmit-side TLP scheduler: round-robins posted, non-posted and completion
// requesters onto one link stream, granting only when FC credits cover the packet.

package tl_tx_fc_pkg;
    typedef struct packed {
        logic [11:0] ph;
        logic [11:0] pd;
        logic [7:0]  nph;
        logic [11:0] npd;
        logic [7:0]  cplh;
        logic [11:0] cpld;
    } tl_credit_t;

    typedef struct packed {
        logic [127:0] data;
        logic         sop;
        logic         eop;
        logic [3:0]   be;
        logic         is_dllp;
    } tl_stream_t;
endpackage

// state | meaning
// ARB   | no grant held; pick first eligible requester at/after rr pointer
// XFER  | granted requester's beats forwarded to the link until eop
module tl_tx_fc_arbiter
    import tl_tx_fc_pkg::*;
#(
    parameter int NSRC = 3,
    parameter int DW   = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NSRC-1:0]     src_valid,
    output logic [NSRC-1:0]     src_ready,
    input  logic [NSRC*DW-1:0]  src_data,
    input  logic [NSRC-1:0]     src_sop,
    input  logic [NSRC-1:0]     src_eop,
    input  logic [NSRC*11-1:0]  src_dw,
    input  tl_credit_t          credit_limit,
    input  logic                fc_init_done,
    output logic                tx_valid,
    input  logic                tx_ready,
    output tl_stream_t          tx_stream,
    output tl_credit_t          credit_consumed,
    output logic                proto_err
);

    typedef enum logic {ARB, XFER} state_t;

    state_t          state_q, state_d;
    logic [1:0]      grant_q, rr_q, pick;
    logic            pick_valid, oversize, first_q;
    logic [NSRC-1:0] drop_q, credit_ok, elig;
    logic [11:0]     dneed [NSRC];
    logic [10:0]     pick_dw;
    tl_credit_t      cons_q;
    logic            g_valid, g_sop, g_eop, beat_fire;
    logic [DW-1:0]   g_data;

    // Wrapping window compare: room is "non-negative" if within half the range.
    function automatic logic fits12(input logic [11:0] lim, input logic [11:0] used,
                                    input logic [11:0] need);
        logic [11:0] room;
        room = lim - (used + need);
        return room <= 12'h800;
    endfunction

    function automatic logic fits8(input logic [7:0] lim, input logic [7:0] used,
                                   input logic [7:0] need);
        logic [7:0] room;
        room = lim - (used + need);
        return room <= 8'h80;
    endfunction

    function automatic logic [1:0] rr_idx(input logic [1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NSRC) s = s - NSRC;
        return 2'(s);
    endfunction

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            dneed[i] = (12'(src_dw[11*i +: 11]) + 12'd3) >> 2;
        end
        credit_ok[0] = fits12(credit_limit.ph, cons_q.ph, 12'd1) &&
                       fits12(credit_limit.pd, cons_q.pd, dneed[0]);
        credit_ok[1] = fits8(credit_limit.nph, cons_q.nph, 8'd1) &&
                       fits12(credit_limit.npd, cons_q.npd, dneed[1]);
        credit_ok[2] = fits8(credit_limit.cplh, cons_q.cplh, 8'd1) &&
                       fits12(credit_limit.cpld, cons_q.cpld, dneed[2]);
    end

    assign elig = credit_ok & src_valid & src_sop & ~drop_q & {NSRC{fc_init_done}};

    always_comb begin
        pick_valid = 1'b0;
        pick       = rr_q;
        for (int k = 0; k < NSRC; k++) begin
            if (!pick_valid && elig[rr_idx(rr_q, k)]) begin
                pick_valid = 1'b1;
                pick       = rr_idx(rr_q, k);
            end
        end
    end

    assign pick_dw   = src_dw[11*pick +: 11];
    assign oversize  = pick_dw > 11'd1024;
    assign g_valid   = src_valid[grant_q];
    assign g_sop     = src_sop[grant_q];
    assign g_eop     = src_eop[grant_q];
    assign g_data    = src_data[DW*grant_q +: DW];
    assign beat_fire = (state_q == XFER) && g_valid && tx_ready;

    always_comb begin
        state_d   = state_q;
        src_ready = '0;
        tx_valid  = 1'b0;
        tx_stream = '0;
        case (state_q)
            ARB: begin
                if (pick_valid && !oversize) state_d = XFER;
            end
            XFER: begin
                tx_valid           = g_valid;
                src_ready[grant_q] = tx_ready;
                tx_stream.data     = g_data;
                tx_stream.sop      = g_sop;
                tx_stream.eop      = g_eop;
                tx_stream.be       = 4'hF;
                tx_stream.is_dllp  = 1'b0;
                if (beat_fire && g_eop) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB;
            grant_q   <= '0;
            rr_q      <= '0;
            first_q   <= 1'b0;
            drop_q    <= '0;
            cons_q    <= '0;
            proto_err <= 1'b0;
        end else begin
            state_q <= state_d;
            // A dropped request stays masked until its requester lowers sop.
            for (int i = 0; i < NSRC; i++) begin
                if (drop_q[i] && !(src_valid[i] && src_sop[i])) drop_q[i] <= 1'b0;
            end
            if (state_q == ARB && pick_valid) begin
                if (oversize) begin
                    proto_err    <= 1'b1;
                    drop_q[pick] <= 1'b1;
                end else begin
                    grant_q <= pick;
                    first_q <= 1'b1;
                    case (pick)
                        2'd0: begin
                            cons_q.ph <= cons_q.ph + 12'd1;
                            cons_q.pd <= cons_q.pd + dneed[0];
                        end
                        2'd1: begin
                            cons_q.nph <= cons_q.nph + 8'd1;
                            cons_q.npd <= cons_q.npd + dneed[1];
                        end
                        default: begin
                            cons_q.cplh <= cons_q.cplh + 8'd1;
                            cons_q.cpld <= cons_q.cpld + dneed[2];
                        end
                    endcase
                end
            end
            if (state_q == XFER) begin
                if (g_valid && g_sop && !first_q) proto_err <= 1'b1;
                if (beat_fire) begin
                    first_q <= 1'b0;
                    if (g_eop) rr_q <= (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
                end
            end
            if (!fc_init_done) cons_q <= '0;
        end
    end

    assign credit_consumed = cons_q;

endmodule

// File: tb/tb_tl_tx_fc_arbiter.sv
// Scoreboard bench for tl_tx_fc_arbiter: requester queues feed the DUT, expected
// link beats are queued at stimulus time and popped as the link accepts them.
module tb_tl_tx_fc_arbiter;
    import tl_tx_fc_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   src_valid = '0;
    logic [2:0]   src_ready;
    logic [383:0] src_data = '0;
    logic [2:0]   src_sop = '0;
    logic [2:0]   src_eop = '0;
    logic [32:0]  src_dw = '0;
    tl_credit_t   credit_limit = '0;
    logic         fc_init_done = 1'b0;
    logic         tx_valid;
    logic         tx_ready = 1'b0;
    tl_stream_t   tx_stream;
    tl_credit_t   credit_consumed;
    logic         proto_err;

    tl_tx_fc_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .src_sop(src_sop), .src_eop(src_eop), .src_dw(src_dw),
        .credit_limit(credit_limit), .fc_init_done(fc_init_done),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_stream(tx_stream),
        .credit_consumed(credit_consumed), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           src;
        logic [127:0] data;
        logic         sop;
        logic         eop;
        logic [10:0]  dw;
    } beat_t;

    beat_t pend[$];
    beat_t sbq[$];
    int    n_chk = 0;
    int    n_bad = 0;
    int    pkt_id = 0;
    int    eop_cnt = 0;
    logic  prev_fire = 1'b0;
    logic [2:0] fire_src = '0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic tl_credit_t mk_cr(input logic [11:0] ph, input logic [11:0] pd,
                                         input logic [7:0] nph, input logic [11:0] npd,
                                         input logic [7:0] cplh, input logic [11:0] cpld);
        tl_credit_t c;
        c.ph = ph; c.pd = pd; c.nph = nph; c.npd = npd; c.cplh = cplh; c.cpld = cpld;
        return c;
    endfunction

    function automatic int head_idx(input int s);
        for (int k = 0; k < pend.size(); k++)
            if (pend[k].src == s) return k;
        return -1;
    endfunction

    // nexp = how many leading beats of this packet are expected on the link
    task automatic push_pkt(input int s, input int nbeats, input logic [10:0] dw, input int nexp);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.src  = s;
            b.data = {32'(s), 32'(pkt_id), 32'(i), 32'hA5A5_0000};
            b.sop  = (i == 0);
            b.eop  = (i == nbeats - 1);
            b.dw   = dw;
            pend.push_back(b);
            if (i < nexp) sbq.push_back(b);
        end
        pkt_id++;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 128'(sbq.size()), 128'd0);
    endtask

    task automatic wait_beat2(input string tag);
        int n = 0;
        while (!(tx_valid && !tx_stream.sop) && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 128'(n < 50), 128'd1);
    endtask

    task automatic do_reset(input tl_credit_t lim, input logic fc);
        tick();
        rst_n = 1'b0;
        pend.delete();
        sbq.delete();
        credit_limit = lim;
        fc_init_done = fc;
        tx_ready = 1'b1;
        eop_cnt = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Requester model and link monitor: drive at negedge, sample before posedge.
    initial begin : drv
        int    h;
        beat_t e;
        logic  fire_tx;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (fire_src[i]) begin
                    h = head_idx(i);
                    if (h >= 0) pend.delete(h);
                end
            end
            fire_src = '0;
            for (int i = 0; i < 3; i++) begin
                h = head_idx(i);
                if (h >= 0) begin
                    src_valid[i] = 1'b1;
                    src_data[128*i +: 128] = pend[h].data;
                    src_sop[i] = pend[h].sop;
                    src_eop[i] = pend[h].eop;
                    src_dw[11*i +: 11] = pend[h].dw;
                end else begin
                    src_valid[i] = 1'b0;
                    src_sop[i] = 1'b0;
                    src_eop[i] = 1'b0;
                end
            end
            #2;
            fire_src = src_valid & src_ready & {3{rst_n}};
            fire_tx  = tx_valid & tx_ready & rst_n;
            if (fire_tx) begin
                if (tx_stream.eop) eop_cnt++;
                if (sbq.size() == 0) begin
                    chk("extra_beat", tx_stream.data, 128'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("beat_data", tx_stream.data, e.data);
                    chk("beat_sop", 128'(tx_stream.sop), 128'(e.sop));
                    chk("beat_eop", 128'(tx_stream.eop), 128'(e.eop));
                    chk("beat_be", 128'(tx_stream.be), 128'hF);
                    if (tx_stream.sop) chk("pkt_gap", 128'(prev_fire), 128'd0);
                end
            end
            prev_fire = fire_tx;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    tl_credit_t   ample;
    logic [127:0] snap;

    initial begin : main
        ample = mk_cr(12'h400, 12'h400, 8'h40, 12'h400, 8'h40, 12'h400);
        #1;
        chk("rst_tx_valid", 128'(tx_valid), 128'd0);
        chk("rst_src_ready", 128'(src_ready), 128'd0);
        chk("rst_credit", 128'(credit_consumed), 128'd0);
        chk("rst_proto_err", 128'(proto_err), 128'd0);
        chk("rst_stream", 128'(tx_stream), 128'd0);

        // credit stall on P, then limit raise
        do_reset(mk_cr(12'd2, 12'd2, 8'd0, 12'd0, 8'd0, 12'd0), 1'b1);
        push_pkt(0, 1, 11'd4, 1);
        push_pkt(0, 1, 11'd4, 1);
        push_pkt(0, 1, 11'd4, 0);
        drain(30, "t1_first_two");
        repeat (5) tick();
        chk("t1_credit_stall", 128'(credit_consumed), 128'(mk_cr(12'd2, 12'd2, 8'd0, 12'd0, 8'd0, 12'd0)));
        chk("t1_stall_txv", 128'(tx_valid), 128'd0);
        chk("t1_stall_rdy", 128'(src_ready[0]), 128'd0);
        credit_limit = mk_cr(12'd3, 12'd3, 8'd0, 12'd0, 8'd0, 12'd0);
        sbq.push_back(pend[0]);
        drain(10, "t1_third");
        chk("t1_credit_after", 128'(credit_consumed), 128'(mk_cr(12'd3, 12'd3, 8'd0, 12'd0, 8'd0, 12'd0)));

        // round robin P, NP, CPL, P
        do_reset(ample, 1'b1);
        push_pkt(0, 1, 11'd1, 1);
        push_pkt(1, 1, 11'd0, 1);
        push_pkt(2, 1, 11'd8, 1);
        push_pkt(0, 1, 11'd1, 1);
        drain(30, "t2_rr");
        chk("t2_credit", 128'(credit_consumed), 128'(mk_cr(12'd2, 12'd2, 8'd1, 12'd0, 8'd1, 12'd2)));

        // cplh wrap through FF -> 00 -> 01
        do_reset(mk_cr(12'd0, 12'd0, 8'd0, 12'd0, 8'h7F, 12'h400), 1'b1);
        for (int i = 0; i < 127; i++) push_pkt(2, 1, 11'd0, 1);
        drain(400, "t3_ramp1");
        credit_limit.cplh = 8'hFE;
        for (int i = 0; i < 127; i++) push_pkt(2, 1, 11'd0, 1);
        drain(400, "t3_ramp2");
        repeat (2) tick();
        chk("t3_cplh_fe", 128'(credit_consumed.cplh), 128'hFE);
        credit_limit.cplh = 8'h01;
        for (int i = 0; i < 3; i++) push_pkt(2, 1, 11'd0, 1);
        push_pkt(2, 1, 11'd0, 0);
        drain(30, "t3_wrap");
        repeat (5) tick();
        chk("t3_cplh_01", 128'(credit_consumed.cplh), 128'h01);
        chk("t3_stall_txv", 128'(tx_valid), 128'd0);

        // no head-of-line blocking: NP starved, CPL passes
        do_reset(mk_cr(12'd0, 12'd0, 8'd0, 12'd0, 8'h40, 12'h400), 1'b1);
        push_pkt(1, 1, 11'd0, 0);
        push_pkt(2, 1, 11'd0, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t4_np_rdy", 128'(src_ready[1]), 128'd0);
        end
        drain(10, "t4_cpl");
        chk("t4_credit", 128'(credit_consumed), 128'(mk_cr(12'd0, 12'd0, 8'd0, 12'd0, 8'd1, 12'd0)));

        // backpressure on beat 2 of a 3-beat P packet, then pointer at NP
        do_reset(ample, 1'b1);
        push_pkt(0, 3, 11'd8, 3);
        wait_beat2("t5_wait_beat2");
        tx_ready = 1'b0;
        #1;
        snap = tx_stream.data;
        chk("t5_rdy_low", 128'(src_ready[0]), 128'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_stable", tx_stream.data, snap);
            chk("t5_held_rdy", 128'(src_ready[0]), 128'd0);
            chk("t5_held_txv", 128'(tx_valid), 128'd1);
        end
        tick();
        tx_ready = 1'b1;
        drain(20, "t5_drain");
        chk("t5_eop_once", 128'(eop_cnt), 128'd1);
        push_pkt(1, 1, 11'd0, 1);
        push_pkt(0, 1, 11'd0, 1);
        drain(20, "t5_rr_np_first");

        // async reset in the middle of an NP packet
        do_reset(ample, 1'b1);
        push_pkt(0, 1, 11'd0, 1);
        drain(10, "t6_first_p");
        push_pkt(1, 3, 11'd0, 1);
        wait_beat2("t6_wait_beat2");
        rst_n = 1'b0;
        #1;
        chk("t6_rst_txv", 128'(tx_valid), 128'd0);
        chk("t6_rst_credit", 128'(credit_consumed), 128'd0);
        chk("t6_rst_rdy", 128'(src_ready), 128'd0);
        pend.delete();
        sbq.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        push_pkt(0, 1, 11'd0, 1);
        push_pkt(1, 1, 11'd0, 1);
        drain(20, "t6_p_first");

        // fc_init_done gating and oversize request
        do_reset(ample, 1'b0);
        push_pkt(0, 1, 11'd1025, 0);
        push_pkt(1, 1, 11'd0, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t7_nofc_txv", 128'(tx_valid), 128'd0);
        end
        chk("t7_nofc_credit", 128'(credit_consumed), 128'd0);
        chk("t7_perr_clear", 128'(proto_err), 128'd0);
        fc_init_done = 1'b1;
        drain(20, "t7_np");
        repeat (3) tick();
        chk("t7_perr_set", 128'(proto_err), 128'd1);
        chk("t7_credit", 128'(credit_consumed), 128'(mk_cr(12'd0, 12'd0, 8'd1, 12'd0, 8'd0, 12'd0)));
        chk("t7_drop_rdy", 128'(src_ready[0]), 128'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
